// File: rtl/vga_timing_gen_if.sv
// Raster/sync output bundle produced by vga_timing_gen.
// Carries frame_cnt only when VGA_FRAME_COUNT_EN is defined.
interface vga_timing_gen_if #(
  parameter int unsigned HW = 10,
  parameter int unsigned VW = 10
);
  logic          pix_stb;
  logic [HW-1:0] hpos;
  logic [VW-1:0] vpos;
  logic          display_on;
  logic          hsync;
  logic          vsync;
  logic          line_start;
  logic          frame_start;
`ifdef VGA_FRAME_COUNT_EN
  logic [7:0]    frame_cnt;
`endif

  modport master (
    output pix_stb, hpos, vpos, display_on, hsync, vsync, line_start, frame_start
`ifdef VGA_FRAME_COUNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    input pix_stb, hpos, vpos, display_on, hsync, vsync, line_start, frame_start
`ifdef VGA_FRAME_COUNT_EN
    , input frame_cnt
`endif
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync / raster-position generator with pixel-clock divider and enable.
// Optional 8-bit frame counter enabled by defining VGA_FRAME_COUNT_EN.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CLK_DIV  = 1,
  parameter int unsigned HW       = 10,
  parameter int unsigned VW       = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  vga_timing_gen_if.master   vid
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [HW-1:0] hpos_q, hpos_d;
  logic [VW-1:0] vpos_q, vpos_d;
  logic          display_on_q, display_on_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          pix_stb;
  logic          h_wrap, v_wrap;

  // Sync/blank/pulse outputs are decoded from the next counter values so they
  // register on the same edge as hpos/vpos and never lag them.
  always_comb begin
    pix_stb       = ena && (div_cnt_q == DIV_LAST);
    h_wrap        = (hpos_q == H_LAST);
    v_wrap        = (vpos_q == V_LAST);
    div_cnt_d     = div_cnt_q;
    hpos_d        = hpos_q;
    vpos_d        = vpos_q;
    display_on_d  = display_on_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (ena) begin
      div_cnt_d = pix_stb ? '0 : div_cnt_q + 1'b1;
    end
    if (pix_stb) begin
      hpos_d = h_wrap ? '0 : hpos_q + 1'b1;
      if (h_wrap) begin
        vpos_d = v_wrap ? '0 : vpos_q + 1'b1;
      end
      display_on_d  = (hpos_d < H_ACT) && (vpos_d < V_ACT);
      hsync_d       = ((hpos_d >= HS_BEG) && (hpos_d <= HS_END)) ? HS_POL : ~HS_POL;
      vsync_d       = ((vpos_d >= VS_BEG) && (vpos_d <= VS_END)) ? VS_POL : ~VS_POL;
      line_start_d  = h_wrap;
      frame_start_d = h_wrap && v_wrap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      hpos_q        <= H_LAST;
      vpos_q        <= V_LAST;
      display_on_q  <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      display_on_q  <= display_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_start_d ? frame_cnt_q + 8'd1 : frame_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= '0;
    else        frame_cnt_q <= frame_cnt_d;
  end

  assign vid.frame_cnt = frame_cnt_q;
`endif

  assign vid.pix_stb     = pix_stb;
  assign vid.hpos        = hpos_q;
  assign vid.vpos        = vpos_q;
  assign vid.display_on  = display_on_q;
  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.line_start  = line_start_q;
  assign vid.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed self-checking bench for vga_timing_gen: default timing, CLK_DIV=2 with
// enable freeze, and a small polarity-inverted configuration run over whole frames.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_n, ena_a, ena_b, ena_c;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.HW(10), .VW(10)) if_a ();
  vga_timing_gen_if #(.HW(10), .VW(10)) if_b ();
  vga_timing_gen_if #(.HW(3),  .VW(3))  if_s ();

  vga_timing_gen u_def (.clk(clk), .rst_n(rst_n), .ena(ena_a), .vid(if_a));

  vga_timing_gen #(.CLK_DIV(2)) u_div (.clk(clk), .rst_n(rst_n), .ena(ena_b), .vid(if_b));

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .HW(3), .VW(3)
  ) u_small (.clk(clk), .rst_n(rst_n), .ena(ena_c), .vid(if_s));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned hs_low, hexp, vexp, dexp, guard, cyc, last_fs, frames, ls_cnt, nc;
    rst_n = 1'b0; ena_a = 1'b0; ena_b = 1'b0; ena_c = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_hpos",  if_a.hpos, 799);
    chk("rst_vpos",  if_a.vpos, 524);
    chk("rst_disp",  if_a.display_on, 0);
    chk("rst_hsync", if_a.hsync, 1);
    chk("rst_vsync", if_a.vsync, 1);
    chk("rst_ls",    if_a.line_start, 0);
    chk("rst_fs",    if_a.frame_start, 0);
    chk("rst_pstb",  if_a.pix_stb, 0);
    chk("s_rst_hpos",  if_s.hpos, 7);
    chk("s_rst_vpos",  if_s.vpos, 5);
    chk("s_rst_hsync", if_s.hsync, 0);
    chk("s_rst_vsync", if_s.vsync, 0);

    // Default timing: first advance wraps to (0,0)
    rst_n = 1'b1; ena_a = 1'b1;
    #1 chk("a_pstb", if_a.pix_stb, 1);
    @(negedge clk);
    chk("a_first_hpos", if_a.hpos, 0);
    chk("a_first_vpos", if_a.vpos, 0);
    chk("a_first_ls",   if_a.line_start, 1);
    chk("a_first_fs",   if_a.frame_start, 1);
    chk("a_first_disp", if_a.display_on, 1);
    hs_low = 0;
    for (int h = 1; h < 800; h++) begin
      @(negedge clk);
      chk("a_hpos",  if_a.hpos, h);
      chk("a_hsync", if_a.hsync, (h >= 656 && h <= 751) ? 0 : 1);
      chk("a_disp",  if_a.display_on, (h < 640) ? 1 : 0);
      chk("a_ls",    if_a.line_start, 0);
      if (if_a.hsync == 1'b0) hs_low++;
    end
    chk("a_hs_low_cnt", hs_low, 96);
    @(negedge clk);
    chk("a_l1_hpos", if_a.hpos, 0);
    chk("a_l1_vpos", if_a.vpos, 1);
    chk("a_l1_ls",   if_a.line_start, 1);
    chk("a_l1_fs",   if_a.frame_start, 0);
    chk("a_l1_disp", if_a.display_on, 1);

    // Asynchronous reset while hsync is asserted
    repeat (700) @(negedge clk);
    chk("a_pre_hsync", if_a.hsync, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_hpos",  if_a.hpos, 799);
    chk("ar_vpos",  if_a.vpos, 524);
    chk("ar_hsync", if_a.hsync, 1);
    chk("ar_disp",  if_a.display_on, 0);
    ena_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("a_hold_hpos", if_a.hpos, 799);

    // CLK_DIV=2: strobe every other cycle, freeze on ena low
    ena_b = 1'b1;
    dexp = 0; hexp = 799; guard = 0;
    while (!(hexp == 100 && dexp == 1) && guard < 1000) begin
      #1;
      chk("b_pstb", if_b.pix_stb, (dexp == 1) ? 1 : 0);
      chk("b_hpos", if_b.hpos, hexp);
      chk("b_ls",   if_b.line_start, (hexp == 0 && dexp == 0) ? 1 : 0);
      @(negedge clk);
      if (dexp == 1) begin
        dexp = 0;
        hexp = (hexp == 799) ? 0 : hexp + 1;
      end else begin
        dexp = 1;
      end
      guard++;
    end
    chk("b_reach_100", (guard < 1000) ? 1 : 0, 1);
    ena_b = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("b_frz_pstb", if_b.pix_stb, 0);
      chk("b_frz_hpos", if_b.hpos, 100);
      chk("b_frz_ls",   if_b.line_start, 0);
      @(negedge clk);
    end
    ena_b = 1'b1;
    #1 chk("b_resume_pstb", if_b.pix_stb, 1);
    @(negedge clk);
    chk("b_resume_hpos", if_b.hpos, 101);
    #1 chk("b_resume_pstb2", if_b.pix_stb, 0);
    ena_b = 1'b0;

    // Small config over whole frames
    ena_c = 1'b1;
    hexp = 7; vexp = 5; cyc = 0; last_fs = 0; frames = 0; ls_cnt = 0;
`ifdef VGA_FRAME_COUNT_EN
    nc = 256 * 48;
    chk("s_fcnt_reset", if_s.frame_cnt, 0);
`else
    nc = 3 * 48;
`endif
    for (int c = 0; c < int'(nc); c++) begin
      @(negedge clk);
      cyc++;
      hexp = (hexp == 7) ? 0 : hexp + 1;
      if (hexp == 0) vexp = (vexp == 5) ? 0 : vexp + 1;
      chk("s_hpos",  if_s.hpos, hexp);
      chk("s_vpos",  if_s.vpos, vexp);
      chk("s_hsync", if_s.hsync, (hexp >= 5 && hexp <= 6) ? 1 : 0);
      chk("s_vsync", if_s.vsync, (vexp == 4) ? 1 : 0);
      chk("s_disp",  if_s.display_on, (hexp < 4 && vexp < 3) ? 1 : 0);
      chk("s_ls",    if_s.line_start, (hexp == 0) ? 1 : 0);
      chk("s_fs",    if_s.frame_start, (hexp == 0 && vexp == 0) ? 1 : 0);
      if (if_s.frame_start == 1'b1) begin
        frames++;
        if (frames > 1) begin
          chk("s_frame_period", cyc - last_fs, 48);
          chk("s_lines_per_frame", ls_cnt, 6);
        end
        last_fs = cyc;
        ls_cnt = 0;
`ifdef VGA_FRAME_COUNT_EN
        chk("s_frame_cnt", if_s.frame_cnt, frames % 256);
`endif
      end
      if (if_s.line_start == 1'b1) ls_cnt++;
    end
    chk("s_frames_seen", frames, nc / 48);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA sync and raster-position generator for the TinyTapeout VGA user design. It replaces the fixed 640x480 timing logic with configurable porch, sync and active widths, selectable sync polarity, a pixel-clock divider and a clock-enable input. It sits directly under the top-level `tt_um_*` wrapper and feeds `hpos`, `vpos` and `display_on` to the pixel generator. It also drives `hsync` and `vsync` onto `uo_out`.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `HS_POL`, 0, hsync active level (0 = active-low)
- `VS_POL`, 0, vsync active level
- `CLK_DIV`, 1, `clk` cycles per pixel (≥1)
- `HW`, 10, width of `hpos`; must satisfy 2^HW ≥ H_TOTAL
- `VW`, 10, width of `vpos`; must satisfy 2^VW ≥ V_TOTAL

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `ena`  in  1  advance enable; when low, all state holds
- `pix_stb`  out  1  pixel strobe, high in cycles where the counters advance
- `hpos`  out  HW  current column
- `vpos`  out  VW  current line
- `display_on`  out  1  high when `hpos` < H_ACTIVE and `vpos` < V_ACTIVE
- `hsync`  out  1  horizontal sync, at level HS_POL when asserted
- `vsync`  out  1  vertical sync, at level VS_POL when asserted
- `line_start`  out  1  one-`clk` pulse when `hpos` becomes 0
- `frame_start`  out  1  one-`clk` pulse when (`hpos`,`vpos`) becomes (0,0)

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
- Divider `div_cnt` counts 0..CLK_DIV-1, advancing only while `ena` is high.
  - `pix_stb` = `ena` && `div_cnt` == CLK_DIV-1.
  - With CLK_DIV=1, `pix_stb` = `ena`.
- On `pix_stb`:
  - `hpos` increments, wrapping H_TOTAL-1 → 0.
  - On that wrap, `vpos` increments, wrapping V_TOTAL-1 → 0.
- hsync is asserted for `hpos` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
- vsync is asserted for `vpos` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
- `ena` low: `div_cnt`, counters and all level outputs hold; `pix_stb`, `line_start` and `frame_start` are 0.
- Simultaneous line and frame wrap: `line_start` and `frame_start` both pulse in the same cycle.

## Timing
- All outputs are registered except `pix_stb`, which is combinational from `div_cnt` and `ena`.
- `hsync`, `vsync`, `display_on` and the pulses update on the same `clk` edge as `hpos`/`vpos`, and are always consistent with the presented `hpos`/`vpos`. There is no pipeline skew; they are decoded from next-count values.
- Pulses are high for exactly one `clk` cycle, in the cycle after the advancing `pix_stb`.
- Reset values:
  - `hpos` = H_TOTAL-1, `vpos` = V_TOTAL-1, `div_cnt` = 0
  - `display_on` = 0, `hsync` = !HS_POL, `vsync` = !VS_POL
  - `line_start` = 0, `frame_start` = 0
  - The first advance after reset therefore wraps to (0,0) and pulses both `line_start` and `frame_start`.
- Reset asserted mid-line or mid-sync returns all outputs to their reset values immediately (asynchronously).
- Reset release is sampled on `clk`. Counting starts on the first cycle in which `ena` is high.

## Configuration
- `VGA_FRAME_COUNT_EN` defined:
  - Adds output `frame_cnt` (8 bits), reset to 0.
  - Increments in the same cycle that `frame_start` pulses; wraps 255 → 0.
  - Holds when `ena` is low.
- `VGA_FRAME_COUNT_EN` undefined: the port and its register are absent. All other behaviour is identical.

## Test plan
- Defaults, CLK_DIV=1, `ena`=1, run one full frame:
  - Exactly 420000 `clk` cycles between consecutive `frame_start` pulses.
  - 525 `line_start` pulses per frame.
  - hsync low for `hpos` 656..751.
  - vsync low for `vpos` 490..491.
  - `display_on` high for 307200 cycles per frame.
- Reset release with `ena`=1: the first cycle produces `hpos`=0, `vpos`=0, `line_start`=1, `frame_start`=1, `display_on`=1.
- CLK_DIV=2: `pix_stb` toggles every cycle and `hpos` advances every 2 cycles. Toggling `ena` low for 5 cycles at `hpos`=100 keeps `hpos`=100 and `div_cnt` frozen for those 5 cycles.
- Small config (H 4/1/2/1, V 3/1/1/1, HS_POL=VS_POL=1):
  - H_TOTAL=8; hsync high at `hpos` 5..6.
  - vsync high at `vpos` 4.
  - A simultaneous wrap at (7,5) → (0,0) pulses both `line_start` and `frame_start`.
- Assert `rst_n` low asynchronously while hsync is asserted: hsync returns to its idle level, `hpos`=H_TOTAL-1 and `display_on`=0 without waiting for a `clk` edge.
- `VGA_FRAME_COUNT_EN` build, small config: `frame_cnt` reads 1 after the first `frame_start`, and wraps to 0 after the 256th frame.
